// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer sitting between the uart FIFOs and program memory.
// Pops command bytes from the RX FIFO, loads 32-bit words into memory ('L'),
// reads single words back through the TX FIFO ('R'), and halts the CPU whenever
// it owns the memory port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a command byte; only state that decodes commands
//   LD_CNT  | popping the word count N of a load
//   LD_BYTE | popping data byte k of the current word (little-endian)
//   LD_WR   | one-cycle memory write of the assembled word
//   RD_ADDR | popping the word address of a read
//   RD_REQ  | one-cycle memory read strobe
//   RD_LAT  | memory read data valid, captured into the shift register
//   RD_SEND | pushing the four read-data bytes, LSB first
//   RSP     | pushing a single ACK/NAK response byte
module uart_cmd_ctrl #(
    parameter int                   DATA_BITS = 8,
    parameter int                   WORD_BITS = 32,
    parameter int                   ADDR_BITS = 8,
    parameter logic [DATA_BITS-1:0] CMD_LOAD  = 8'h4C,
    parameter logic [DATA_BITS-1:0] CMD_READ  = 8'h52,
    parameter logic [DATA_BITS-1:0] RSP_ACK   = 8'h06,
    parameter logic [DATA_BITS-1:0] RSP_NAK   = 8'h15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 rd_uart,
    input  logic                 tx_full,
    output logic [DATA_BITS-1:0] w_data,
    output logic                 wr_uart,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    output logic                 cpu_halt,
    output logic                 busy
);

    typedef enum logic [3:0] {
        IDLE,
        LD_CNT,
        LD_BYTE,
        LD_WR,
        RD_ADDR,
        RD_REQ,
        RD_LAT,
        RD_SEND,
        RSP
    } state_t;

    state_t               state;
    logic [7:0]           cnt;
    logic [7:0]           idx;
    logic [1:0]           k;
    logic [WORD_BITS-1:0] shift;
    logic                 consuming;
    logic                 sending;

    // Classify states that pop the RX FIFO or push the TX FIFO.
    always_comb begin
        consuming = (state == IDLE) || (state == LD_CNT) ||
                    (state == LD_BYTE) || (state == RD_ADDR);
        sending   = (state == RD_SEND) || (state == RSP);
    end

    // FIFO handshakes are combinational so a byte moves in the same cycle the FIFO allows it.
    assign rd_uart  = reset & consuming & ~rx_empty;
    assign wr_uart  = reset & sending & ~tx_full;
    // Both read data and response bytes leave through the low byte of the shift register.
    assign w_data   = sending ? shift[DATA_BITS-1:0] : '0;
    assign cpu_halt = (state != IDLE);
    assign busy     = cpu_halt;

    // Command sequencing FSM with registered memory strobes, address and write data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            k         <= '0;
            shift     <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_uart) begin
                        if (r_data == CMD_LOAD) begin
                            state <= LD_CNT;
                        end else if (r_data == CMD_READ) begin
                            state <= RD_ADDR;
                        end else begin
                            shift <= WORD_BITS'(RSP_NAK);
                            state <= RSP;
                        end
                    end
                end
                LD_CNT: begin
                    if (rd_uart) begin
                        cnt <= 8'(r_data);
                        idx <= '0;
                        k   <= '0;
                        if (r_data == '0) begin
                            shift <= WORD_BITS'(RSP_ACK);
                            state <= RSP;
                        end else begin
                            state <= LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (rd_uart) begin
                        shift[int'(k)*DATA_BITS +: DATA_BITS] <= r_data;
                        if (k == 2'd3) begin
                            // The last byte goes straight into the write data so the strobe follows next cycle.
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_BITS'(idx);
                            mem_wdata <= {r_data, shift[WORD_BITS-DATA_BITS-1:0]};
                            state     <= LD_WR;
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                LD_WR: begin
                    idx <= idx + 8'd1;
                    k   <= '0;
                    if ((idx + 8'd1) == cnt) begin
                        shift <= WORD_BITS'(RSP_ACK);
                        state <= RSP;
                    end else begin
                        state <= LD_BYTE;
                    end
                end
                RD_ADDR: begin
                    if (rd_uart) begin
                        mem_addr <= ADDR_BITS'(r_data);
                        mem_re   <= 1'b1;
                        state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    state <= RD_LAT;
                end
                RD_LAT: begin
                    shift <= mem_rdata;
                    k     <= '0;
                    state <= RD_SEND;
                end
                RD_SEND: begin
                    if (wr_uart) begin
                        shift <= shift >> DATA_BITS;
                        k     <= k + 2'd1;
                        if (k == 2'd3) begin
                            state <= IDLE;
                        end
                    end
                end
                RSP: begin
                    if (wr_uart) begin
                        shift <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: RX/TX FIFO and memory models around the DUT, a
// command-stream interpreter producing expected writes and TX bytes, and one
// per-cycle compare process.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic [7:0]  w_data;
    logic        wr_uart;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        cpu_halt;
    logic        busy;

    uart_cmd_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_halt  (cpu_halt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  cmd[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] ram[256];
    logic [31:0] ref_mem[256];
    int          pop_cyc[$];
    int          push_cyc[$];

    int         cyc = 0;
    int         full_cnt = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] re_addr = 8'h00;
    logic [7:0] rd_addr_q = 8'h00;
    bit         rd_pending = 1'b0;
    bit         gap_mode = 1'b0;
    bit         stall_arm = 1'b0;
    bit         halt_track = 1'b0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Interpret cmd[] as a command stream and append what the sequencer must produce.
    task automatic model_stream();
        int          p;
        int          n;
        logic [7:0]  a;
        logic [31:0] w;
        p = 0;
        while (p < cmd.size()) begin
            if (cmd[p] == 8'h4C) begin
                n = int'(cmd[p+1]);
                p += 2;
                for (int i = 0; i < n; i++) begin
                    w = {cmd[p+3], cmd[p+2], cmd[p+1], cmd[p]};
                    p += 4;
                    exp_wa.push_back(8'(i));
                    exp_wd.push_back(w);
                    ref_mem[i] = w;
                end
                exp_tx.push_back(8'h06);
            end else if (cmd[p] == 8'h52) begin
                a = cmd[p+1];
                p += 2;
                w = ref_mem[a];
                for (int j = 0; j < 4; j++) exp_tx.push_back(w[8*j +: 8]);
            end else begin
                exp_tx.push_back(8'h15);
                p += 1;
            end
        end
    endtask

    task automatic start_test();
        we_cnt = 0;
        re_cnt = 0;
        tx_cnt = 0;
        pop_cyc.delete();
        push_cyc.delete();
    endtask

    task automatic send_cmd(input bit modeled);
        foreach (cmd[i]) rx_q.push_back(cmd[i]);
        if (modeled) model_stream();
    endtask

    task automatic wait_done(input string name);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            done = (rx_q.size() == 0) && (exp_tx.size() == 0) &&
                   (exp_wa.size() == 0) && (cpu_halt == 1'b0);
        end
        check_eq(name, 64'(done), 64'd1);
    endtask

    // FIFO/memory models and the per-cycle compare against the expected queues.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            rx_empty  = (rx_q.size() == 0) || (gap_mode && (cyc % 3 != 0));
            r_data    = (rx_q.size() != 0) ? rx_q[0] : 8'hEE;
            tx_full   = (full_cnt > 0);
            if (full_cnt > 0) full_cnt--;
            mem_rdata = rd_pending ? ram[rd_addr_q] : 32'h0BADF00D;
            rd_pending = 1'b0;
            #1;
            if (!reset) begin
                check_eq("outputs in reset",
                         64'({rd_uart, wr_uart, w_data, mem_we, mem_re, mem_addr, mem_wdata, cpu_halt, busy}),
                         64'd0);
            end else begin
                check_eq("busy equals cpu_halt", 64'(busy), 64'(cpu_halt));
                check_eq("no pop while rx empty", 64'(rd_uart & rx_empty), 64'd0);
                check_eq("no push while tx full", 64'(wr_uart & tx_full), 64'd0);
                check_eq("halt during activity", 64'((mem_we | mem_re | wr_uart) & ~cpu_halt), 64'd0);
                if (!cpu_halt && !rx_empty) check_eq("idle pops available byte", 64'(rd_uart), 64'd1);
                if (halt_track && pop_cyc.size() > 0 && exp_tx.size() > 0)
                    check_eq("halt held mid command", 64'(cpu_halt), 64'd1);
                if (rd_uart) begin
                    pop_cyc.push_back(cyc);
                    void'(rx_q.pop_front());
                end
                if (wr_uart) begin
                    tx_cnt++;
                    push_cyc.push_back(cyc);
                    check_eq("tx push expected", 64'(exp_tx.size() != 0), 64'd1);
                    if (exp_tx.size() != 0) check_eq("tx byte", 64'(w_data), 64'(exp_tx.pop_front()));
                    if (stall_arm) begin
                        full_cnt  = 50;
                        stall_arm = 1'b0;
                    end
                end
                if (mem_we) begin
                    we_cnt++;
                    check_eq("mem_we expected", 64'(exp_wa.size() != 0), 64'd1);
                    if (exp_wa.size() != 0) begin
                        check_eq("mem_we addr", 64'(mem_addr), 64'(exp_wa.pop_front()));
                        check_eq("mem_we data", 64'(mem_wdata), 64'(exp_wd.pop_front()));
                    end
                    if (pop_cyc.size() != 0) check_eq("mem_we latency", 64'(cyc - pop_cyc[$]), 64'd1);
                    ram[mem_addr] = mem_wdata;
                end
                if (mem_re) begin
                    re_cnt++;
                    re_addr    = mem_addr;
                    rd_addr_q  = mem_addr;
                    rd_pending = 1'b1;
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram[5]     = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        reset     = 1'b0;
        rx_empty  = 1'b1;
        tx_full   = 1'b0;
        r_data    = 8'h00;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset cpu_halt", 64'(cpu_halt), 64'd0);
        check_eq("reset mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: two-word load then ACK
        start_test();
        halt_track = 1'b1;
        cmd = '{8'h4C, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_cmd(1'b1);
        check_eq("model word0", 64'(exp_wd[0]), 64'h44332211);
        check_eq("model word1", 64'(exp_wd[1]), 64'h88776655);
        check_eq("model ack", 64'(exp_tx[0]), 64'h06);
        wait_done("t1 complete");
        check_eq("t1 write count", 64'(we_cnt), 64'd2);
        check_eq("t1 tx count", 64'(tx_cnt), 64'd1);
        halt_track = 1'b0;

        // 2: zero-length load
        start_test();
        cmd = '{8'h4C, 8'h00};
        send_cmd(1'b1);
        wait_done("t2 complete");
        check_eq("t2 write count", 64'(we_cnt), 64'd0);
        check_eq("t2 tx count", 64'(tx_cnt), 64'd1);

        // 3: read back mem[5]
        start_test();
        cmd = '{8'h52, 8'h05};
        send_cmd(1'b1);
        check_eq("model rd byte0", 64'(exp_tx[0]), 64'hEF);
        check_eq("model rd byte3", 64'(exp_tx[3]), 64'hDE);
        wait_done("t3 complete");
        check_eq("t3 read count", 64'(re_cnt), 64'd1);
        check_eq("t3 read addr", 64'(re_addr), 64'd5);
        check_eq("t3 tx count", 64'(tx_cnt), 64'd4);
        check_eq("t3 have cycles", 64'(push_cyc.size() >= 1 && pop_cyc.size() >= 2), 64'd1);
        if (push_cyc.size() >= 1 && pop_cyc.size() >= 2)
            check_eq("t3 read latency", 64'(push_cyc[0] - pop_cyc[1]), 64'd3);

        // 4: read with TX FIFO full for 50 cycles after the first push
        start_test();
        stall_arm = 1'b1;
        cmd = '{8'h52, 8'h05};
        send_cmd(1'b1);
        wait_done("t4 complete");
        check_eq("t4 tx count", 64'(tx_cnt), 64'd4);
        check_eq("t4 have cycles", 64'(push_cyc.size() >= 2), 64'd1);
        if (push_cyc.size() >= 2)
            check_eq("t4 stall gap", 64'(push_cyc[1] - push_cyc[0]), 64'd51);

        // 5: unknown command then read of mem[0], with RX gaps
        start_test();
        gap_mode = 1'b1;
        cmd = '{8'h7A, 8'h52, 8'h00};
        send_cmd(1'b1);
        check_eq("model nak", 64'(exp_tx[0]), 64'h15);
        check_eq("model mem0 byte0", 64'(exp_tx[1]), 64'h11);
        wait_done("t5 complete");
        gap_mode = 1'b0;
        check_eq("t5 tx count", 64'(tx_cnt), 64'd5);
        check_eq("t5 read addr", 64'(re_addr), 64'd0);

        // 6: reset in the middle of a load, then a clean load
        start_test();
        cmd = '{8'h4C, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        send_cmd(1'b0);
        for (int n = 0; n < 200 && rx_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6 bytes consumed", 64'(rx_q.size()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_eq("t6 no write on abort", 64'(we_cnt), 64'd0);
        check_eq("t6 no response on abort", 64'(tx_cnt), 64'd0);
        start_test();
        cmd = '{8'h4C, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        send_cmd(1'b1);
        check_eq("model t6 word", 64'(exp_wd[0]), 64'h04030201);
        wait_done("t6 complete");
        check_eq("t6 write count", 64'(we_cnt), 64'd1);
        check_eq("t6 ram word", 64'(ram[0]), 64'h04030201);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
